// File: rtl/fcnn_pkg.sv
// Shared types and sizes for the 784-30-10 network front end.
package fcnn_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int IMG_PIXELS = 784;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } loader_state_e;

endpackage

// File: rtl/pixel_frame_loader.sv
// Serial pixel stream -> parallel frame buffer feeding the network's iData.
// Optional build macro: PIXEL_LOADER_LAST_CHECK_EN (pixLast checking, frameErr, DRAIN state).
module pixel_frame_loader
  import fcnn_pkg::*;
#(
  parameter int dataWidth = DATA_WIDTH,
  parameter int NoPixels  = IMG_PIXELS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pixValid,
  output logic                               pixReady,
  input  logic [dataWidth-1:0]               pixData,
  input  logic                               pixLast,
  output logic [NoPixels-1:0][dataWidth-1:0] frameData,
  output logic                               frameValid,
  input  logic                               frameAck,
  output logic                               frameErr
);

  localparam int CntW = $clog2(NoPixels);
  localparam logic [CntW-1:0] LastIdx = CntW'(NoPixels - 1);

  loader_state_e   state;
  logic [CntW-1:0] cnt;
  logic            accept;

  assign accept = pixValid && pixReady;

`ifndef PIXEL_LOADER_LAST_CHECK_EN
  logic unused_last;
  assign unused_last = pixLast;
  assign frameErr    = 1'b0;
`endif

  // pixReady/frameValid are flops, so neither handshake input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      cnt        <= '0;
      pixReady   <= 1'b0;
      frameValid <= 1'b0;
      // NOTE: the buffer is flops, not RAM, so it can and must be cleared on reset.
      frameData  <= '0;
`ifdef PIXEL_LOADER_LAST_CHECK_EN
      frameErr   <= 1'b0;
`endif
    end else begin
`ifdef PIXEL_LOADER_LAST_CHECK_EN
      frameErr <= 1'b0;
`endif
      case (state)
        LOAD: begin
          pixReady <= 1'b1;
          if (accept) begin
            frameData[cnt] <= pixData;
            if (cnt == LastIdx) begin
              cnt <= '0;
`ifdef PIXEL_LOADER_LAST_CHECK_EN
              if (pixLast) begin
                state      <= HOLD;
                pixReady   <= 1'b0;
                frameValid <= 1'b1;
              end else begin
                state    <= DRAIN;
                frameErr <= 1'b1;
              end
`else
              state      <= HOLD;
              pixReady   <= 1'b0;
              frameValid <= 1'b1;
`endif
            end
`ifdef PIXEL_LOADER_LAST_CHECK_EN
            else if (pixLast) begin
              // Short image: restart counting, leave stale entries in place.
              cnt      <= '0;
              frameErr <= 1'b1;
            end
`endif
            else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        HOLD: begin
          if (frameAck) begin
            state      <= LOAD;
            pixReady   <= 1'b1;
            frameValid <= 1'b0;
          end
        end

`ifdef PIXEL_LOADER_LAST_CHECK_EN
        DRAIN: begin
          pixReady <= 1'b1;
          if (accept && pixLast) state <= LOAD;
        end
`endif

        // NOTE: an explicit recovery arm keeps an unused encoding from locking the FSM.
        default: begin
          state      <= LOAD;
          cnt        <= '0;
          pixReady   <= 1'b1;
          frameValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader: framing, hold/ack, malformed images, resets, gaps.
module tb_pixel_frame_loader;
  import fcnn_pkg::*;

  localparam int N = IMG_PIXELS;

  logic clk = 1'b0;
  logic rst, pixValid, pixReady, pixLast, frameValid, frameAck, frameErr;
  pixel_t pixData;
  logic [N-1:0][DATA_WIDTH-1:0] frameData;

  pixel_t exp_frame [N];
  int tests = 0;
  int fails = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  pixel_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .pixValid  (pixValid),
    .pixReady  (pixReady),
    .pixData   (pixData),
    .pixLast   (pixLast),
    .frameData (frameData),
    .frameValid(frameValid),
    .frameAck  (frameAck),
    .frameErr  (frameErr)
  );

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, failed so far %0d", fails);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-chosen pixel patterns; the cast to pixel_t is the mod-256 reduction.
  function automatic pixel_t pix_val(input int kind, input int i);
    int v;
    case (kind)
      0:       v = i;
      1:       v = 255;
      2:       v = 3 * i + 1;
      3:       v = i ^ 'h5A;
      4:       v = 5 * i + 7;
      default: v = 0;
    endcase
    return pixel_t'(v);
  endfunction

  task automatic set_exp(input int kind, input int start, input int n);
    for (int k = 0; k < n; k++) exp_frame[start+k] = pix_val(kind, start + k);
  endtask

  task automatic clear_exp();
    for (int k = 0; k < N; k++) exp_frame[k] = '0;
  endtask

  function automatic int frame_diff();
    int d = 0;
    for (int k = 0; k < N; k++) if (frameData[k] !== exp_frame[k]) d++;
    return d;
  endfunction

  task automatic send_pixel(input pixel_t d, input logic last, input bit gaps);
    int budget;
    if (gaps && $urandom_range(1, 0) == 1) begin
      pixValid = 1'b0;
      step();
    end
    pixValid = 1'b1;
    pixData  = d;
    pixLast  = last;
    budget   = 0;
    while (pixReady !== 1'b1 && budget < 1000) begin
      step();
      budget++;
    end
    if (budget >= 1000) check("ready_timeout", 0, 1);
    step();
  endtask

  task automatic send_stream(input int kind, input int start, input int n,
                             input int last_at, input bit gaps);
    for (int k = 0; k < n; k++)
      send_pixel(pix_val(kind, start + k), (start + k) == last_at, gaps);
    pixValid = 1'b0;
    pixLast  = 1'b0;
  endtask

  task automatic ack_frame(input string tag);
    frameAck = 1'b1;
    step();
    frameAck = 1'b0;
    check({tag, "_ack_valid"}, frameValid, 0);
    check({tag, "_ack_ready"}, pixReady, 1);
  endtask

  initial begin
    int c0;
    int ready_hi;

    rst = 1'b1; pixValid = 1'b0; pixLast = 1'b0; pixData = '0; frameAck = 1'b0;
    repeat (3) step();
    check("rst_ready", pixReady, 0);
    check("rst_valid", frameValid, 0);
    check("rst_err", frameErr, 0);
    clear_exp();
    check("rst_frame", frame_diff(), 0);
    rst = 1'b0;
    step();
    check("post_rst_ready", pixReady, 1);
    check("post_rst_valid", frameValid, 0);

    // Image A: index mod 256, no gaps
    c0 = cycle;
    send_stream(0, 0, N - 1, -1, 0);
    check("a_valid_early", frameValid, 0);
    send_stream(0, N - 1, 1, N - 1, 0);
    check("a_latency", cycle - c0, N);
    check("a_valid", frameValid, 1);
    check("a_ready", pixReady, 0);
    check("a_pix300", frameData[300], 44);
    set_exp(0, 0, N);
    check("a_frame", frame_diff(), 0);

    // Hold for 50 cycles with upstream pushing
    pixValid = 1'b1; pixData = 8'h55; pixLast = 1'b1;
    ready_hi = 0;
    repeat (50) begin
      step();
      if (pixReady) ready_hi++;
    end
    check("hold_ready_cnt", ready_hi, 0);
    check("hold_valid", frameValid, 1);
    check("hold_frame", frame_diff(), 0);
    frameAck = 1'b1;
    step();
    frameAck = 1'b0; pixValid = 1'b0; pixLast = 1'b0;
    check("a_ack_valid", frameValid, 0);
    check("a_ack_ready", pixReady, 1);

    // Image B: all 0xFF
    send_stream(1, 0, N, N - 1, 0);
    check("b_valid", frameValid, 1);
    set_exp(1, 0, N);
    check("b_frame", frame_diff(), 0);
    ack_frame("b");

`ifdef PIXEL_LOADER_LAST_CHECK_EN
    // Early pixLast on pixel 99, then image C
    send_stream(4, 0, 100, 99, 0);
    check("early_err", frameErr, 1);
    check("early_valid", frameValid, 0);
    send_stream(2, 0, 1, -1, 0);
    check("early_err_pulse", frameErr, 0);
    send_stream(2, 1, N - 2, -1, 0);
    check("c_valid_early", frameValid, 0);
    send_stream(2, N - 1, 1, N - 1, 0);
    check("c_valid", frameValid, 1);
    check("c_pix0", frameData[0], 1);
    set_exp(2, 0, N);
    check("c_frame", frame_diff(), 0);
    ack_frame("c");

    // 800 pixels, pixLast only on 799, then image D
    send_stream(4, 0, N, -1, 0);
    check("miss_err", frameErr, 1);
    check("miss_valid", frameValid, 0);
    check("miss_ready", pixReady, 1);
    send_stream(4, N, 15, -1, 0);
    check("miss_err_pulse", frameErr, 0);
    check("drain_ready", pixReady, 1);
    send_stream(4, N + 15, 1, N + 15, 0);
    check("drain_valid", frameValid, 0);
    check("drain_err", frameErr, 0);
`else
    // pixLast ignored: the early marker does not break the frame
    send_stream(4, 0, 100, 99, 0);
    check("early_err", frameErr, 0);
    check("early_valid", frameValid, 0);
    send_stream(2, 100, N - 100, -1, 0);
    check("c_valid", frameValid, 1);
    set_exp(4, 0, 100);
    set_exp(2, 100, N - 100);
    check("c_frame", frame_diff(), 0);
    ack_frame("c");

    // No pixLast at all: frame completes on count
    send_stream(4, 0, N, -1, 0);
    check("miss_valid", frameValid, 1);
    check("miss_err", frameErr, 0);
    set_exp(4, 0, N);
    check("miss_frame", frame_diff(), 0);
    ack_frame("miss");
`endif

    send_stream(3, 0, N, N - 1, 0);
    check("d_valid", frameValid, 1);
    set_exp(3, 0, N);
    check("d_frame", frame_diff(), 0);
    ack_frame("d");

    // Random valid gaps: same frame as the gap-free run, valid right after last accept
    send_stream(0, 0, N - 1, -1, 1);
    check("g_valid_early", frameValid, 0);
    send_stream(0, N - 1, 1, N - 1, 1);
    check("g_valid", frameValid, 1);
    set_exp(0, 0, N);
    check("g_frame", frame_diff(), 0);
    ack_frame("g");

    // Reset at pixel 400
    send_stream(2, 0, 400, -1, 0);
    pixValid = 1'b1; pixData = 8'hEE; rst = 1'b1;
    step();
    pixValid = 1'b0;
    check("r1_ready", pixReady, 0);
    check("r1_valid", frameValid, 0);
    check("r1_err", frameErr, 0);
    clear_exp();
    check("r1_frame", frame_diff(), 0);
    rst = 1'b0;
    step();
    check("r1_post_ready", pixReady, 1);

    // Reset during HOLD
    send_stream(1, 0, N, N - 1, 0);
    check("r2_hold_valid", frameValid, 1);
    rst = 1'b1;
    step();
    check("r2_ready", pixReady, 0);
    check("r2_valid", frameValid, 0);
    check("r2_frame", frame_diff(), 0);
    rst = 1'b0;
    step();
    check("r2_post_ready", pixReady, 1);
    check("r2_post_valid", frameValid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_frame_loader.md
# pixel_frame_loader

Front-end stage of the 784-30-10 network. Accepts a serial stream of 8-bit greyscale pixels over a valid/ready handshake and assembles them into a 784-entry frame buffer. The buffer's array output feeds the network's `iData` input directly. The loader holds each completed frame stable until the network side acknowledges it, then accepts the next image.

## Interface
- `dataWidth`, default 8: pixel width in bits; must equal the network's `dataWidth`.
- `NoPixels`, default 784: pixels per frame (28x28, row-major).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `pixValid`  in  1: upstream pixel valid.
- `pixReady`  out  1: loader can accept a pixel.
- `pixData`  in  `dataWidth`: pixel value.
- `pixLast`  in  1: marks the final pixel of an image.
- `frameData`  out  `[dataWidth-1:0]` x `[NoPixels-1:0]`: assembled frame; index 0 is the first pixel received.
- `frameValid`  out  1: `frameData` is complete and stable.
- `frameAck`  in  1: consumer has taken the frame.
- `frameErr`  out  1: one-cycle pulse when a malformed image is detected.

## Operation
- Accept = `pixValid && pixReady` in a cycle.
- States:
  - `LOAD`: `pixReady`=1. On accept, `frameData[cnt] <= pixData` and `cnt` increments.
  - `HOLD`: `frameValid`=1, `pixReady`=0, `frameData` frozen.
  - `DRAIN`: `pixReady`=1, accepted pixels are discarded.
- `LOAD` -> `HOLD`: accept with `cnt == NoPixels-1` and `pixLast`=1. `cnt` returns to 0.
- `HOLD` -> `LOAD`: `frameAck`=1. `frameAck` is ignored in `LOAD` and `DRAIN`.
- Early `pixLast` (accept with `pixLast`=1 and `cnt < NoPixels-1`):
  - `frameErr` pulses; `cnt` returns to 0; stay in `LOAD`.
  - Stale buffer entries are not cleared; `frameValid` is not raised.
- Missing `pixLast` (accept at `cnt == NoPixels-1` with `pixLast`=0):
  - `frameErr` pulses; `cnt` returns to 0; go to `DRAIN`.
  - `DRAIN` -> `LOAD` on the accept with `pixLast`=1.
- `cnt` is `$clog2(NoPixels)` bits wide and never exceeds `NoPixels-1`. No arithmetic is applied to pixel data.
- Reset values:
  - state=`LOAD`, `cnt`=0.
  - `frameValid`=0, `frameErr`=0, `pixReady`=1 (from the cycle after reset is released).
  - All `frameData` entries = 0.
  - While `rst`=1, `pixReady`=0.
- Reset mid-frame or in `HOLD`: the partial or held frame is discarded; nothing is delivered.

## Timing
- `pixReady` and `frameValid` decode from registered state only; there is no combinational path from `pixValid` or `frameAck`.
- Throughput: one pixel per cycle in `LOAD`.
- Latency: `frameValid` rises the cycle after the final pixel is accepted.
- `frameAck` in cycle t while `frameValid`=1: `frameValid`=0 and `pixReady`=1 in cycle t+1.
- Minimum image period: `NoPixels` + 1 cycles (ack held high).
- `frameErr` is registered: it is high for exactly the cycle after the offending accept.
- `frameData[i]` updates the cycle after its pixel is accepted.

## Configuration
- `PIXEL_LOADER_LAST_CHECK_EN` defined: `pixLast` checking, `frameErr`, and the `DRAIN` state are as described above.
- `PIXEL_LOADER_LAST_CHECK_EN` undefined:
  - `pixLast` is ignored; a frame completes purely on count (`cnt == NoPixels-1` accept -> `HOLD`).
  - `DRAIN` is not built; `frameErr` is tied to 0.

## Structure
- Shared package `fcnn_pkg`:
  - `DATA_WIDTH` = 8, `IMG_PIXELS` = 784.
  - `pixel_t` typedef.
  - Loader state enum `loader_state_e` (`LOAD`, `HOLD`, `DRAIN`).
- Single module, no sub-module. The frame buffer is a register array written at index `cnt`; it is not a RAM, because the network needs all 784 pixels in parallel.

## Test plan
- Reset, then stream pixels 0..783 with `pixData = index mod 256`, `pixLast` on the last pixel, `pixValid` held high -> `frameValid`=1 on cycle 785, `frameData[300]`=44, `pixReady`=0 until ack.
- Hold `frameAck`=0 for 50 cycles with `pixValid`=1 -> no pixel accepted and `frameData` unchanged. Pulse `frameAck` -> `pixReady`=1 next cycle; second image (all 0xFF) is delivered correctly.
- Assert `pixLast` on pixel 99 -> `frameErr` pulses once, `frameValid` stays 0; a following full 784-pixel image is delivered with `frameData[0]` taken from the first pixel after the error.
- Send 800 pixels with `pixLast` only on pixel 799 -> `frameErr` after pixel 783, pixels 784..799 dropped, no frame delivered; the next image is loaded normally. With the macro undefined: frame delivered after pixel 783, `frameErr` never asserts.
- Assert `rst` at pixel 400, then again during `HOLD` -> all outputs return to reset values the next cycle; `frameData` reads all zeros.
- Random `pixValid` gaps (50% duty) -> frame is identical to the gap-free run; `frameValid` rises exactly one cycle after the 784th accept.
